// File: rtl/game_pkg.sv
// Shared types and constants for the duck-hunt round controller.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    FLYING,
    FLEEING,
    DUCK_DONE,
    ROUND_END,
    FINISHED
  } game_state_e;

  localparam int unsigned SCORE_W        = 16;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 16'hFFFF;
  localparam int unsigned PERFECT_BONUS  = 500;
  localparam int unsigned DEF_HIT_POINTS = 100;

  // Saturating score addition; the game-over screen must never wrap.
  function automatic logic [SCORE_W-1:0] score_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/mouse_click_edge.sv
// Registered rising-edge detector on a mouse button level; a held button yields one pulse.
module mouse_click_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic click_o
);

  logic btn_q;
  logic click_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q   <= 1'b0;
      click_q <= 1'b0;
    end else begin
      btn_q   <= btn_i;
      click_q <= btn_i & ~btn_q;
    end
  end

  assign click_o = click_q;

endmodule

// File: rtl/game_round_ctrl.sv
// Duck-hunt session controller: rounds, ducks, shots and score.
// Optional perfect-round bonus enabled by defining GAME_ROUND_PERFECT_BONUS_EN.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS      = 3,
  parameter int unsigned DUCKS_PER_ROUND = 4,
  parameter int unsigned SHOTS_PER_DUCK  = 3,
  parameter int unsigned MIN_HITS        = 2,
  parameter int unsigned HIT_POINTS      = DEF_HIT_POINTS,
  parameter int unsigned FLY_TIMEOUT     = 650_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         game_enable,
  input  logic         left_mouse,
  input  logic         duck_hit,
  input  logic         duck_escaped,
  output logic         duck_spawn,
  output logic         duck_flee,
  output logic         game_finished,
  output logic [15:0]  score,
  output logic [3:0]   round_num,
  output logic [1:0]   shots_left
);

  localparam int unsigned TIMER_W = (FLY_TIMEOUT > 2) ? $clog2(FLY_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] LAST_TICK  = TIMER_W'(FLY_TIMEOUT - 1);
  localparam logic [3:0]         LAST_DUCK  = 4'(DUCKS_PER_ROUND - 1);
  localparam logic [3:0]         LAST_ROUND = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0]         MIN_HITS_C = 4'(MIN_HITS);
  localparam logic [1:0]         SHOTS_C    = 2'(SHOTS_PER_DUCK);
  localparam logic [SCORE_W-1:0] HIT_PTS    = SCORE_W'(HIT_POINTS);
`ifdef GAME_ROUND_PERFECT_BONUS_EN
  localparam logic [3:0]         ALL_DUCKS  = 4'(DUCKS_PER_ROUND);
  localparam logic [SCORE_W-1:0] BONUS_PTS  = SCORE_W'(PERFECT_BONUS);
`endif

  game_state_e        state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         round_q, round_d;
  logic [3:0]         duck_q, duck_d;
  logic [3:0]         hits_q, hits_d;
  logic [1:0]         shots_q, shots_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               spawn_q, spawn_d;
  logic               flee_q, flee_d;
  logic               fin_q, fin_d;
  logic               shot;

  mouse_click_edge u_click (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (left_mouse),
    .click_o (shot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      score_q <= '0;
      round_q <= '0;
      duck_q  <= '0;
      hits_q  <= '0;
      shots_q <= '0;
      timer_q <= '0;
      spawn_q <= 1'b0;
      flee_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      round_q <= round_d;
      duck_q  <= duck_d;
      hits_q  <= hits_d;
      shots_q <= shots_d;
      timer_q <= timer_d;
      spawn_q <= spawn_d;
      flee_q  <= flee_d;
      fin_q   <= fin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    round_d = round_q;
    duck_d  = duck_q;
    hits_d  = hits_q;
    shots_d = shots_q;
    timer_d = timer_q;
    spawn_d = 1'b0;
    flee_d  = 1'b0;

    // Losing enable mid-game abandons the session silently.
    if (!game_enable && state_q != IDLE && state_q != FINISHED) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (game_enable) begin
            score_d = '0;
            round_d = '0;
            duck_d  = '0;
            hits_d  = '0;
            state_d = SPAWN;
          end
        end
        SPAWN: begin
          spawn_d = 1'b1;
          shots_d = SHOTS_C;
          timer_d = '0;
          state_d = FLYING;
        end
        FLYING: begin
          timer_d = timer_q + TIMER_W'(1);
          if (shot && shots_q != 2'd0) shots_d = shots_q - 2'd1;
          // A hit outranks an escape or a last-shot flee in the same cycle.
          if (duck_hit) begin
            score_d = score_add(score_q, HIT_PTS);
            hits_d  = hits_q + 4'd1;
            state_d = DUCK_DONE;
          end else if (duck_escaped) begin
            state_d = DUCK_DONE;
          end else if ((shot && shots_q == 2'd1) || timer_q == LAST_TICK) begin
            flee_d  = 1'b1;
            state_d = FLEEING;
          end
        end
        FLEEING: begin
          if (duck_escaped) state_d = DUCK_DONE;
        end
        DUCK_DONE: begin
          if (duck_q == LAST_DUCK) begin
            duck_d  = '0;
            state_d = ROUND_END;
          end else begin
            duck_d  = duck_q + 4'd1;
            state_d = SPAWN;
          end
        end
        ROUND_END: begin
`ifdef GAME_ROUND_PERFECT_BONUS_EN
          if (hits_q == ALL_DUCKS) score_d = score_add(score_q, BONUS_PTS);
`endif
          if (hits_q < MIN_HITS_C || round_q == LAST_ROUND) begin
            state_d = FINISHED;
          end else begin
            round_d = round_q + 4'd1;
            hits_d  = '0;
            state_d = SPAWN;
          end
        end
        FINISHED: begin
          if (!game_enable) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    fin_d = (state_d == FINISHED);
  end

  assign duck_spawn    = spawn_q;
  assign duck_flee     = flee_q;
  assign game_finished = fin_q;
  assign score         = score_q;
  assign round_num     = round_q;
  assign shots_left    = shots_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Scoreboard bench for game_round_ctrl: stimulus queues expected events, a monitor checks them.
module tb_game_round_ctrl;
  import game_pkg::*;

  localparam int unsigned FLY_TO = 50;
`ifdef GAME_ROUND_PERFECT_BONUS_EN
  localparam int BONUS = 500;
`else
  localparam int BONUS = 0;
`endif

  localparam logic [1:0] EV_SPAWN = 2'd0;
  localparam logic [1:0] EV_FLEE  = 2'd1;
  localparam logic [1:0] EV_FIN   = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] score;
    logic [3:0]  round;
    logic [1:0]  shots;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst, game_enable, left_mouse, duck_hit, duck_escaped;
  logic        duck_spawn, duck_flee, game_finished;
  logic [15:0] score;
  logic [3:0]  round_num;
  logic [1:0]  shots_left;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  logic fin_prev = 1'b0;

  game_round_ctrl #(.FLY_TIMEOUT(FLY_TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .game_enable   (game_enable),
    .left_mouse    (left_mouse),
    .duck_hit      (duck_hit),
    .duck_escaped  (duck_escaped),
    .duck_spawn    (duck_spawn),
    .duck_flee     (duck_flee),
    .game_finished (game_finished),
    .score         (score),
    .round_num     (round_num),
    .shots_left    (shots_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input int sc, input int rnd, input int sh);
    ev_t e;
    e.kind  = kind;
    e.score = 16'(sc);
    e.round = 4'(rnd);
    e.shots = 2'(sh);
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [1:0] kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", int'(kind), int'(e.kind));
      check("ev_score", int'(score), int'(e.score));
      check("ev_round", int'(round_num), int'(e.round));
      check("ev_shots", int'(shots_left), int'(e.shots));
    end
  endtask

  // Output monitor: every pulse or finish edge must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (duck_spawn) observe(EV_SPAWN);
      if (duck_flee) observe(EV_FLEE);
      if (game_finished && !fin_prev) observe(EV_FIN);
    end
    fin_prev = game_finished;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_hit();
    duck_hit = 1'b1;
    tick();
    duck_hit = 1'b0;
  endtask

  task automatic pulse_esc();
    duck_escaped = 1'b1;
    tick();
    duck_escaped = 1'b0;
  endtask

  task automatic click();
    left_mouse = 1'b1;
    tick();
    left_mouse = 1'b0;
    tick();
  endtask

  // Hit lands in the same cycle the FSM sees the shot edge.
  task automatic click_hit();
    left_mouse = 1'b1;
    tick();
    left_mouse = 1'b0;
    duck_hit   = 1'b1;
    tick();
    duck_hit   = 1'b0;
  endtask

  // which: 0 = duck_spawn, 1 = game_finished; bounded wait.
  task automatic wait_for(input int which, input string name);
    int k;
    k = 0;
    while (((which == 0) ? !duck_spawn : !game_finished) && k < 20) begin
      tick();
      k++;
    end
    if ((which == 0) ? !duck_spawn : !game_finished) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got timeout after %0d cycles expected event", name, k);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; game_enable = 1'b0; left_mouse = 1'b0;
    duck_hit = 1'b0; duck_escaped = 1'b0;
    tick(3);
    rst = 1'b0;
    tick();
    check("rst_score", int'(score), 0);
    check("rst_round", int'(round_num), 0);
    check("rst_shots", int'(shots_left), 0);
    check("rst_spawn", int'(duck_spawn), 0);
    check("rst_flee", int'(duck_flee), 0);
    check("rst_fin", int'(game_finished), 0);

    // Start: spawn two cycles after enable, then three misses and a flee.
    push(EV_SPAWN, 0, 0, 3);
    game_enable = 1'b1;
    tick();
    check("spawn_early", int'(duck_spawn), 0);
    tick();
    check("spawn_latency", int'(duck_spawn), 1);
    check("shots_init", int'(shots_left), 3);
    click();
    check("shots_after1", int'(shots_left), 2);
    click();
    check("shots_after2", int'(shots_left), 1);
    push(EV_FLEE, 0, 0, 0);
    click();
    check("shots_after3", int'(shots_left), 0);
    check("flee_on_last_shot", int'(duck_flee), 1);
    pulse_hit();
    tick(2);
    check("hit_ignored_fleeing", int'(score), 0);
    push(EV_SPAWN, 0, 0, 3);
    pulse_esc();
    wait_for(0, "spawn_duck1");

    // Hit on the final shot edge wins over the flee.
    click();
    click();
    push(EV_SPAWN, 100, 0, 3);
    click_hit();
    check("hit_last_shot_score", int'(score), 100);
    check("hit_last_shot_noflee", int'(duck_flee), 0);
    wait_for(0, "spawn_duck2");
    push(EV_SPAWN, 100, 0, 3);
    pulse_esc();
    wait_for(0, "spawn_duck3");

    // One hit in round 0 ends the game after the fourth duck.
    push(EV_FIN, 100, 0, 3);
    pulse_esc();
    wait_for(1, "finish_round0");
    tick(10);
    check("fin_held", int'(game_finished), 1);
    game_enable = 1'b0;
    tick();
    check("fin_dropped", int'(game_finished), 0);
    tick(3);
    check("idle_score_kept", int'(score), 100);
    check("idle_round_kept", int'(round_num), 0);

    // Perfect game: every duck hit across three rounds.
    push(EV_SPAWN, 0, 0, 3);
    game_enable = 1'b1;
    wait_for(0, "spawn_perfect0");
    for (int i = 0; i < 12; i++) begin
      if (i < 11) push(EV_SPAWN, 100 * (i + 1) + BONUS * ((i + 1) / 4), (i + 1) / 4, 3);
      else push(EV_FIN, 1200 + 3 * BONUS, 2, 3);
      pulse_hit();
      if (i < 11) wait_for(0, "spawn_perfect");
      else wait_for(1, "finish_perfect");
    end
    check("perfect_round", int'(round_num), 2);
    check("perfect_score", int'(score), 1200 + 3 * BONUS);
    check("perfect_fin", int'(game_finished), 1);
    game_enable = 1'b0;
    tick(2);
    check("perfect_idle_score", int'(score), 1200 + 3 * BONUS);
    check("perfect_idle_fin", int'(game_finished), 0);

    // Abort mid-flight: back to IDLE with no pulses; new game clears score.
    push(EV_SPAWN, 0, 0, 3);
    game_enable = 1'b1;
    wait_for(0, "spawn_abort");
    click();
    check("abort_shots", int'(shots_left), 2);
    game_enable = 1'b0;
    tick();
    check("abort_no_spawn", int'(duck_spawn), 0);
    check("abort_no_flee", int'(duck_flee), 0);
    tick(5);
    push(EV_SPAWN, 0, 0, 3);
    game_enable = 1'b1;
    tick();
    check("restart_spawn_early", int'(duck_spawn), 0);
    tick();
    check("restart_spawn_latency", int'(duck_spawn), 1);

    // Timeout: idle duck flees on its 50th flying cycle.
    push(EV_FLEE, 0, 0, 3);
    tick(FLY_TO - 1);
    check("timeout_early", int'(duck_flee), 0);
    tick();
    check("timeout_flee", int'(duck_flee), 1);
    push(EV_SPAWN, 0, 0, 3);
    pulse_esc();
    wait_for(0, "spawn_after_timeout");
    game_enable = 1'b0;
    tick(4);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Game-side counterpart of the top-level game control FSM.
- Consumes `game_enable` and runs the duck-hunt session: rounds, ducks per round, shots per duck, score.
- Drives `game_finished` back to the control FSM once the session ends.
- Sits between the control FSM, the mouse interface, the duck motion/draw logic and the hit-detection logic.

Parameters:
- NUM_ROUNDS, 3, rounds per game (1..15)
- DUCKS_PER_ROUND, 4, ducks spawned per round (1..15)
- SHOTS_PER_DUCK, 3, shots allowed per duck (1..3)
- MIN_HITS, 2, hits per round required to continue
- HIT_POINTS, 100, score added per hit
- FLY_TIMEOUT, 650_000_000, max cycles a duck stays in FLYING before fleeing

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- game_enable  in  1  level from control FSM, high while game runs
- left_mouse  in  1  mouse button level
- duck_hit  in  1  1-cycle pulse from hit detection (click on duck)
- duck_escaped  in  1  1-cycle pulse from duck logic, duck left the screen
- duck_spawn  out  1  1-cycle pulse, launch a new duck
- duck_flee  out  1  1-cycle pulse, command current duck to fly away
- game_finished  out  1  level, held until game_enable falls
- score  out  16  accumulated score, saturating
- round_num  out  4  current round, 0-based
- shots_left  out  2  remaining shots for current duck

Behaviour:
- Reset: state=IDLE; all outputs 0; internal counters 0. All outputs are registered.
- Shot detection: rising edge of `left_mouse`, registered, so a shot is seen 1 cycle after the click. A button held high counts once.
- IDLE: when `game_enable`=1, clear score, round_num, duck index and round hits, then go to SPAWN.
- SPAWN (1 cycle): duck_spawn=1, shots_left<=SHOTS_PER_DUCK, fly timer<=0, then go to FLYING.
- FLYING:
  - Each shot edge with shots_left>0 decrements shots_left.
  - duck_hit: score+=HIT_POINTS (saturate at 16'hFFFF), round_hits+1, go to DUCK_DONE.
  - duck_escaped: go to DUCK_DONE as a miss.
  - shots_left reaching 0 without a hit, or timer==FLY_TIMEOUT-1: duck_flee pulse, go to FLEEING.
  - duck_hit coincident with the last shot edge: the hit wins and no flee is issued.
  - duck_hit coincident with duck_escaped: the hit wins.
- FLEEING: shots are ignored and duck_hit is ignored. Wait for duck_escaped, then go to DUCK_DONE.
- DUCK_DONE (1 cycle):
  - If duck index == DUCKS_PER_ROUND-1: clear the duck index, go to ROUND_END.
  - Otherwise: duck index+1, go to SPAWN.
- ROUND_END (1 cycle):
  - If round_hits<MIN_HITS or round_num==NUM_ROUNDS-1: go to FINISHED.
  - Otherwise: round_num+1, round_hits<=0, go to SPAWN.
- FINISHED: game_finished=1, held. When game_enable=0, drop game_finished and go to IDLE. This covers the 1-cycle control FSM registration delay.
- Abort: game_enable=0 in any state other than IDLE or FINISHED sends the block to IDLE next cycle with no pulses issued.
- Score and round_num are retained in IDLE for the game-over screen. They are cleared only on the next game start.
- Reset mid-game returns to IDLE immediately, with all outputs 0.

Optional Feature:
- Macro: GAME_ROUND_PERFECT_BONUS_EN.
- Defined: in ROUND_END, if round_hits==DUCKS_PER_ROUND, score+=PERFECT_BONUS (package constant, 500), saturating. The bonus applies to the final round too.
- Undefined: no bonus; score changes only on hits.

Decomposition:
- game_pkg holds:
  - the state enum typedef (IDLE, SPAWN, FLYING, FLEEING, DUCK_DONE, ROUND_END, FINISHED);
  - SCORE_W=16, SCORE_MAX, PERFECT_BONUS;
  - default HIT_POINTS.
- Sub-module mouse_click_edge: 2-flop rising-edge detector on left_mouse. It is reused by the start/game-over click logic.

Test Plan:
- Reset, then game_enable=1 → duck_spawn pulse exactly 2 cycles after enable; shots_left=3; score=0; round_num=0.
- 3 clicks, no hit → shots_left 3→2→1→0, duck_flee pulse, duck_hit then ignored; duck_escaped → next duck_spawn; score unchanged.
- duck_hit in the same cycle as the 3rd shot edge → score=100, no duck_flee.
- Round 0 with 1 hit in 4 ducks → game_finished=1 after the 4th duck; game_finished holds until game_enable=0; IDLE keeps score=100.
- All 12 ducks hit (bonus macro off) → round_num reaches 2, final score=1200, game_finished=1; with the macro defined, score=2700.
- game_enable dropped mid-FLYING, or FLY_TIMEOUT=50 in bench with no input → abort: IDLE next cycle; timeout: duck_flee at cycle 50 of FLYING.
